// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator CPU: opcodes, sequencer states
// and data_bus_out driver selects, used by the control unit and the datapath.
package cpu_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_NOP = 3'b000;
  localparam logic [OPW-1:0] OP_LDA = 3'b001;
  localparam logic [OPW-1:0] OP_STA = 3'b010;
  localparam logic [OPW-1:0] OP_ADD = 3'b011;
  localparam logic [OPW-1:0] OP_LDI = 3'b100;
  localparam logic [OPW-1:0] OP_JMP = 3'b101;
  localparam logic [OPW-1:0] OP_JZ  = 3'b110;
  localparam logic [OPW-1:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [1:0] BUS_NONE    = 2'b00;
  localparam logic [1:0] BUS_OPERAND = 2'b01;
  localparam logic [1:0] BUS_SUM     = 2'b10;
  localparam logic [1:0] BUS_AC      = 2'b11;

endpackage

// File: rtl/mem_timeout_timer.sv
// Counts wait cycles of an outstanding memory request; expired flags that the
// count has reached MEM_TIMEOUT. Saturates there so it can never wrap.
module mem_timeout_timer #(
  parameter int TW          = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TW-1:0] r_count;

  assign expired = (r_count == TW'(MEM_TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer: drives AC/PC/IR strobes and the memory
// request/ack handshake, halting with a sticky error on a memory timeout.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int OPW         = cpu_pkg::OPW,
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] ir_opcode,
  input  logic           ac_zero,
  input  logic           mem_ack,
  output logic           mem_req,
  output logic           mem_we,
  output logic           addr_sel,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           ld_ac,
  output logic           source_ac,
  output logic [1:0]     bus_sel,
  output logic           halted,
  output logic           mem_err,
  output logic [2:0]     state_dbg
);

  state_e r_state;
  state_e w_state_next;
  logic   r_halted;
  logic   r_mem_err;
  logic   w_timeout;
  logic   w_expired;
  logic   w_tmr_clear;
  logic   w_tmr_enable;

  // Any state change clears the counter, so each FETCH/EXEC starts from zero.
  assign w_tmr_clear  = (w_state_next != r_state);
  assign w_tmr_enable = mem_req && !mem_ack;

  mem_timeout_timer #(
    .TW          (TW),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_tmr_clear),
    .enable  (w_tmr_enable),
    .expired (w_expired)
  );

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ld_ir        = 1'b0;
    inc_pc       = 1'b0;
    ld_pc        = 1'b0;
    ld_ac        = 1'b0;
    source_ac    = 1'b0;
    bus_sel      = BUS_NONE;

    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ld_ir        = 1'b1;
          inc_pc       = 1'b1;
          w_state_next = ST_DECODE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = ST_HALT;
        end
      end
      ST_DECODE: begin
        w_state_next = ST_FETCH;
        case (ir_opcode)
          OP_LDI: begin
            ld_ac     = 1'b1;
            source_ac = 1'b1;
            bus_sel   = BUS_OPERAND;
          end
          OP_JMP:                 ld_pc = 1'b1;
          OP_JZ:                  ld_pc = ac_zero;
          OP_HLT:                 w_state_next = ST_HALT;
          OP_LDA, OP_STA, OP_ADD: w_state_next = ST_EXEC;
          default:                ;
        endcase
      end
      ST_EXEC: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (ir_opcode == OP_STA) begin
          mem_we  = 1'b1;
          bus_sel = BUS_AC;
        end
        if (mem_ack) begin
          if (ir_opcode == OP_LDA) begin
            ld_ac = 1'b1;
          end else if (ir_opcode == OP_ADD) begin
            ld_ac     = 1'b1;
            source_ac = 1'b1;
            bus_sel   = BUS_SUM;
          end
          w_state_next = ST_FETCH;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (start) w_state_next = ST_FETCH;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_halted  <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_halted <= (w_state_next == ST_HALT);
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end else if ((r_state == ST_HALT) && start) begin
        r_mem_err <= 1'b0;
      end
    end
  end

  assign halted    = r_halted;
  assign mem_err   = r_mem_err;
  assign state_dbg = r_state;

endmodule
